// File: rtl/timer_counter.sv
// timer_counter -- memory-mapped down-counting timer with interrupt.
//
// Register map (addr):
//   0 CTRL   : [0] EN count enable, [2:1] MODE (01 auto-reload, else one-shot),
//              [3] IM interrupt mask; [31:4] read as 0
//   1 PRESET : 32-bit reload value, read/write
//   2 COUNT  : 32-bit current count, read-only
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   addr  : register select
//   we    : write enable for the selected register
//   din   : write data
//   dout  : combinational read data for the selected register
//   irq   : interrupt request, IM AND irq_flag
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag;

  logic        ctrl_we, preset_we;
  logic        en, auto_reload, im;
  logic        en_clr, flag_set, flag_clr_auto;

  assign ctrl_we     = we && (addr == 2'd0);
  assign preset_we   = we && (addr == 2'd1);
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign im          = ctrl[3];

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    en_clr        = 1'b0;
    flag_set      = 1'b0;
    flag_clr_auto = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // Terminal count: clamp to 0 (covers PRESET of 0 and 1 alike).
          count_nxt = 32'd0;
          state_nxt = ST_INT;
          flag_set  = 1'b1;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        if (auto_reload) flag_clr_auto = 1'b1;
        else             en_clr        = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;

      // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
      if (ctrl_we)     ctrl    <= din[3:0];
      else if (en_clr) ctrl[0] <= 1'b0;

      if (preset_we) preset <= din;

      // Setting the flag takes priority over any clear on the same edge.
      if (flag_set)                        irq_flag <= 1'b1;
      else if (ctrl_we || flag_clr_auto)   irq_flag <= 1'b0;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'd0;
    endcase
  end

  assign irq = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed testbench for timer_counter. Each task drives a scenario and
// compares DUT outputs against hand-derived values; a summary line ends the run.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec;
  int n_err;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL reset_dout addr=%0d got=%h exp=%h", a, v, 32'd0);
      end
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    wr(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL ctrl_upper_bits got=%h exp=%h", v, 32'd0);
    end
    wr(2'd1, 32'hDEAD_BEEF);
    rd(2'd1, v);
    n_vec++;
    if (v !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL preset_rw got=%h exp=%h", v, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] v;
    logic [31:0] exp_cnt;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);           // enable edge E0
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_cnt = (k < 2) ? 32'd0 : 32'(7 - k);
      rd(2'd2, v);
      n_vec++;
      if (v !== exp_cnt) begin
        n_err++;
        $display("FAIL oneshot_count E%0d got=%0d exp=%0d", k, v, exp_cnt);
      end
      n_vec++;
      if (irq !== (k == 7)) begin
        n_err++;
        $display("FAIL oneshot_irq E%0d got=%b exp=%b", k, irq, (k == 7));
      end
    end
    for (int k = 0; k < 3; k++) tick();
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_irq_hold got=%b exp=1", irq);
    end
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL oneshot_ctrl got=%h exp=%h", v, 32'h8);
    end
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL oneshot_count_final got=%0d exp=0", v);
    end
    wr(2'd0, 32'h8);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_irq_clear got=%b exp=0", irq);
    end
  endtask

  // Period is six edges: IDLE->LOAD, LOAD, two decrements, INT entry, INT->IDLE.
  task automatic test_auto_reload();
    logic [31:0] v;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);           // E0
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k < 2) begin
        exp_cnt = 32'd0;
        exp_irq = 1'b0;
      end else begin
        p = (k - 2) % 6;
        exp_cnt = (p == 0) ? 32'd3 : (p == 1) ? 32'd2 : (p == 2) ? 32'd1 : 32'd0;
        exp_irq = (p == 3);
      end
      rd(2'd2, v);
      n_vec++;
      if (v !== exp_cnt) begin
        n_err++;
        $display("FAIL auto_count E%0d got=%0d exp=%0d", k, v, exp_cnt);
      end
      n_vec++;
      if (irq !== exp_irq) begin
        n_err++;
        $display("FAIL auto_irq E%0d got=%b exp=%b", k, irq, exp_irq);
      end
    end
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'hB) begin
      n_err++;
      $display("FAIL auto_ctrl got=%h exp=%h", v, 32'hB);
    end
  endtask

  task automatic test_mid_count();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);           // E0
    for (int k = 0; k < 12; k++) tick();
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd10) begin
      n_err++;
      $display("FAIL mid_count_at10 got=%0d exp=10", v);
    end
    wr(2'd0, 32'h8);           // still enabled on this edge: one more decrement
    for (int k = 0; k < 3; k++) tick();
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd9) begin
      n_err++;
      $display("FAIL mid_stop_hold got=%0d exp=9", v);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_stop_irq got=%b exp=0", irq);
    end
    wr(2'd2, 32'h55);
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd9) begin
      n_err++;
      $display("FAIL count_readonly got=%0d exp=9", v);
    end
    wr(2'd3, 32'hFFFF);
    rd(2'd3, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL reserved_read got=%h exp=0", v);
    end
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL reserved_no_ctrl got=%h exp=%h", v, 32'h8);
    end
    rd(2'd1, v);
    n_vec++;
    if (v !== 32'd20) begin
      n_err++;
      $display("FAIL reserved_no_preset got=%0d exp=20", v);
    end
    wr(2'd0, 32'h1);           // F0
    tick(); tick(); tick();    // F3: count 19
    wr(2'd1, 32'd2);           // F4: count 18
    tick();                    // F5: count 17
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd17) begin
      n_err++;
      $display("FAIL preset_mid_count got=%0d exp=17", v);
    end
    wr(2'd0, 32'h0);           // F6: count 16, then IDLE
    tick(); tick();
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd16) begin
      n_err++;
      $display("FAIL stop2_hold got=%0d exp=16", v);
    end
    wr(2'd0, 32'h1);           // G0
    tick(); tick();            // G2: new preset loaded
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd2) begin
      n_err++;
      $display("FAIL preset_next_load got=%0d exp=2", v);
    end
    tick(); tick();            // G4: terminal, masked
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL preset2_end got=%0d exp=0", v);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL preset2_masked_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_masked_zero();
    logic [31:0] v;
    do_reset();
    wr(2'd0, 32'h1);           // PRESET is 0 after reset
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (irq !== 1'b0) begin
        n_err++;
        $display("FAIL masked_irq step%0d got=%b exp=0", k, irq);
      end
    end
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL zero_preset_count got=%0d exp=0", v);
    end
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL zero_preset_ctrl got=%h exp=0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);           // E0
    tick(); tick();            // E2: count 1
    wr(2'd0, 32'h9);           // E3: terminal set beats CTRL-write clear
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL set_over_clear got=%b exp=1", irq);
    end
    wr(2'd0, 32'h9);           // E4: INT edge, CPU write beats EN clear
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'h9) begin
      n_err++;
      $display("FAIL cpu_wins_ctrl got=%h exp=%h", v, 32'h9);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL collision_irq_clear got=%b exp=0", irq);
    end
    tick(); tick();            // E6: reloaded to 1
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd1 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL restart_load got=%0d/%b exp=1/0", v, irq);
    end
    tick();                    // E7: INT again
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL restart_irq got=%b exp=1", irq);
    end
    tick();                    // E8: one-shot EN clear
    rd(2'd0, v);
    n_vec++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL restart_ctrl got=%h exp=%h", v, 32'h8);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL reset_mid addr=%0d got=%h exp=0", a, v);
      end
    end
    wr(2'd1, 32'd4);
    for (int k = 0; k < 8; k++) tick();
    rd(2'd2, v);
    n_vec++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL no_restart got=%0d exp=0", v);
    end
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_irq got=%b exp=1", irq);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq_drop got=%b exp=0", irq);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    addr  = 2'd0;
    we    = 1'b0;
    din   = 32'd0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mid_count();
    test_masked_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
